gshare_predictor: RTL and testbench
===================================

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 6, giving the pattern-history-table index width (2^INDEX_BITS entries).
REQ-002 The block SHALL have parameter HIST_BITS, default 6, giving the global-history width; HIST_BITS <= INDEX_BITS.
REQ-003 The block SHALL have parameter CTR_WIDTH, default 2, giving the saturating counter width per entry.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port lookup_pc, input, 32 bits: fetch-stage PC.
REQ-007 The block SHALL have port predict_taken, output, 1 bit: prediction for lookup_pc.
REQ-008 The block SHALL have port predict_index, output, INDEX_BITS: table index used, carried down the pipe.
REQ-009 The block SHALL have port update_valid, input, 1 bit: a resolved conditional branch this cycle.
REQ-010 The block SHALL have port update_index, input, INDEX_BITS: predict_index captured at fetch.
REQ-011 The block SHALL have port update_taken, input, 1 bit: actual outcome.
REQ-012 The block SHALL have port update_mispredict, input, 1 bit: the prediction was wrong.
REQ-013 The block SHALL have port branch_count, output, 32 bits: resolved branches.
REQ-014 The block SHALL have port mispredict_count, output, 32 bits: mispredicted branches.

Function
REQ-015 predict_index SHALL equal lookup_pc[INDEX_BITS+1:2] XOR zero-extended ghr, combinationally.
REQ-016 predict_taken SHALL equal the MSB of table[predict_index], combinationally, with zero cycles of lookup latency.
REQ-017 On update_valid, table[update_index] SHALL increment by 1 when update_taken=1 and decrement by 1 when update_taken=0, taking effect on the next edge.
REQ-018 Counter saturation: an all-ones counter with taken, or an all-zeros counter with not-taken, SHALL hold its value; there SHALL be no wrap-around.
REQ-019 On update_valid, ghr SHALL shift left with update_taken into bit 0; the oldest bit is dropped.
REQ-020 ghr and the table SHALL NOT change on cycles with update_valid=0.
REQ-021 When a lookup and an update hit the same index in the same cycle, the lookup SHALL return the pre-update counter, with no bypass, and SHALL use the pre-shift ghr.
REQ-022 On update_valid, branch_count SHALL increment by 1, and mispredict_count SHALL increment by 1 when update_mispredict=1.
REQ-023 Both statistic counters SHALL wrap modulo 2^32.
REQ-024 update_mispredict SHALL be ignored when update_valid=0.

Reset
REQ-025 On a clk edge with reset_n=0, all table entries SHALL be set to 0 (strongly not-taken), ghr to 0, and branch_count and mispredict_count to 0.
REQ-026 Reset SHALL take priority over a simultaneous update.
REQ-027 predict_taken SHALL read 0 in the first cycle after reset for any lookup_pc.
REQ-028 Reset asserted mid-operation SHALL discard all history and training with no residual state.

Structure
REQ-029 INDEX_BITS, HIST_BITS and CTR_WIDTH defaults and the counter-next function (saturating inc/dec) SHALL reside in shared package bp_pkg.
REQ-030 The per-entry counter SHALL be sub-module bp_sat_ctr, which has a synchronous active-low reset, a write enable, a taken input and an MSB output, and is instantiated 2^INDEX_BITS times.
REQ-031 ghr and the statistic counters SHALL be implemented in the top level.

Verification
REQ-032 The bench SHALL cover: reset, then lookup_pc=0x0000_0040 -> predict_index=0x10, predict_taken=0, both counts 0.
REQ-033 The bench SHALL cover: 3 taken updates to index 5 with ghr forced to 0 by prior not-taken updates -> counter 3, predict_taken=1 once lookup maps to 5; a 4th taken update holds the counter at 3.
REQ-034 The bench SHALL cover: 5 consecutive not-taken updates to an all-zero entry -> entry stays 0, ghr=0, branch_count=5.
REQ-035 The bench SHALL cover: updates with taken sequence 1,0,1,1 -> ghr=0b001011; lookup_pc=0x0000_0000 gives predict_index=0x0B.
REQ-036 The bench SHALL cover: a same-cycle lookup and update on index 7, counter 1, taken -> predict_taken=0 that cycle and 1 the next.
REQ-037 The bench SHALL cover: mispredict_count preloaded near 0xFFFF_FFFF by 2^32-1 mispredicts, or by a forced value, then one more -> mispredict_count wraps to 0; a reset_n pulse mid-training returns all entries to 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared defaults and the saturating-counter update rule for the branch predictor.
// The counter helper works at a fixed maximum width so any CTR_WIDTH up to CTR_MAX_W can reuse it.
package bp_pkg;

    localparam int INDEX_BITS_DEF = 6;
    localparam int HIST_BITS_DEF  = 6;
    localparam int CTR_WIDTH_DEF  = 2;
    localparam int CTR_MAX_W      = 8;

    // Saturating increment/decrement of a counter whose real width is `width`.
    function automatic logic [CTR_MAX_W-1:0] sat_ctr_next(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 taken,
        input int                   width
    );
        logic [CTR_MAX_W-1:0] max_val;
        max_val = {CTR_MAX_W{1'b1}} >> (CTR_MAX_W - width);
        if (taken) begin
            return (ctr == max_val) ? ctr : ctr + CTR_MAX_W'(1);
        end else begin
            return (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
        end
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// One pattern-history-table entry: a saturating up/down counter exposing its MSB
// as the taken/not-taken prediction.
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int CTR_WIDTH = CTR_WIDTH_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic we,
    input  logic taken,
    output logic msb
);

    logic [CTR_WIDTH-1:0] ctr_reg;
    logic [CTR_WIDTH-1:0] ctr_next;
    logic [CTR_MAX_W-1:0] ctr_ext;

    always_comb begin
        ctr_ext  = CTR_MAX_W'(ctr_reg);
        ctr_next = CTR_WIDTH'(sat_ctr_next(ctr_ext, taken, CTR_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctr_reg <= '0;
        end else if (we) begin
            ctr_reg <= ctr_next;
        end
    end

    assign msb = ctr_reg[CTR_WIDTH-1];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare conditional-branch predictor: PC bits XOR global history index a table of
// saturating counters; also keeps resolved-branch and misprediction statistics.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int HIST_BITS  = HIST_BITS_DEF,
    parameter int CTR_WIDTH  = CTR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           lookup_pc,
    output logic                  predict_taken,
    output logic [INDEX_BITS-1:0] predict_index,
    input  logic                  update_valid,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic                  update_taken,
    input  logic                  update_mispredict,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);

    localparam int TABLE_SIZE = 1 << INDEX_BITS;

    logic [HIST_BITS-1:0]  ghr_reg;
    logic [HIST_BITS-1:0]  ghr_next;
    logic [31:0]           branch_count_reg;
    logic [31:0]           mispredict_count_reg;
    logic [TABLE_SIZE-1:0] ctr_msb;
    logic                  unused_pc_bits;

    // Word-aligned PC: the two low bits and the bits above the index never matter.
    assign unused_pc_bits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0]};

    assign predict_index = lookup_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_reg);
    // Reads registered counter state only, so a same-cycle update is not bypassed.
    assign predict_taken = ctr_msb[predict_index];

    generate
        for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_pht
            bp_sat_ctr #(
                .CTR_WIDTH (CTR_WIDTH)
            ) u_ctr (
                .clk     (clk),
                .reset_n (reset_n),
                .we      (update_valid && (update_index == INDEX_BITS'(gi))),
                .taken   (update_taken),
                .msb     (ctr_msb[gi])
            );
        end
    endgenerate

    assign ghr_next = (ghr_reg << 1) | HIST_BITS'(update_taken);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ghr_reg              <= '0;
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else if (update_valid) begin
            ghr_reg          <= ghr_next;
            branch_count_reg <= branch_count_reg + 32'd1;
            if (update_mispredict) begin
                mispredict_count_reg <= mispredict_count_reg + 32'd1;
            end
        end
    end

    assign branch_count     = branch_count_reg;
    assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor: a driver pushes expected outputs computed
// from an array-based predictor model; a negedge monitor pops and compares them.
module tb_gshare_predictor;

    localparam int IB = 6;
    localparam int HB = 6;
    localparam int CW = 2;
    localparam int N  = 1 << IB;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   lookup_pc = '0;
    logic          predict_taken;
    logic [IB-1:0] predict_index;
    logic          update_valid = 1'b0;
    logic [IB-1:0] update_index = '0;
    logic          update_taken = 1'b0;
    logic          update_mispredict = 1'b0;
    logic [31:0]   branch_count;
    logic [31:0]   mispredict_count;

    always #5 clk = ~clk;

    gshare_predictor #(
        .INDEX_BITS (IB),
        .HIST_BITS  (HB),
        .CTR_WIDTH  (CW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .lookup_pc         (lookup_pc),
        .predict_taken     (predict_taken),
        .predict_index     (predict_index),
        .update_valid      (update_valid),
        .update_index      (update_index),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    typedef struct {
        string       tag;
        logic [31:0] idx;
        logic [31:0] tk;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: counters as plain integers, history as an integer.
    int          m_tbl[N];
    int          m_ghr = 0;
    logic [31:0] m_bc = '0;
    logic [31:0] m_mc = '0;
    bit          model_ok = 1'b0;

    function automatic logic [31:0] pc_for(input int target);
        logic [31:0] r;
        r = $urandom;
        return (r & 32'hFFFF_FF03) | (32'((target ^ m_ghr) % N) << 2);
    endfunction

    task automatic cycle(input string tag, input logic rn, input logic [31:0] pc,
                         input logic uv, input int ui, input logic ut, input logic um);
        exp_t e;
        int   idx;
        @(posedge clk);
        #1;
        reset_n           = rn;
        lookup_pc         = pc;
        update_valid      = uv;
        update_index      = IB'(ui);
        update_taken      = ut;
        update_mispredict = um;
        if (model_ok) begin
            idx   = int'((pc / 4) % N) ^ m_ghr;
            e.tag = tag;
            e.idx = 32'(idx);
            e.tk  = (m_tbl[idx] >= (1 << (CW - 1))) ? 32'd1 : 32'd0;
            e.bc  = m_bc;
            e.mc  = m_mc;
            sb_q.push_back(e);
        end
        if (!rn) begin
            foreach (m_tbl[i]) m_tbl[i] = 0;
            m_ghr    = 0;
            m_bc     = '0;
            m_mc     = '0;
            model_ok = 1'b1;
        end else if (uv) begin
            if (ut) m_tbl[ui] = (m_tbl[ui] == (1 << CW) - 1) ? m_tbl[ui] : m_tbl[ui] + 1;
            else    m_tbl[ui] = (m_tbl[ui] == 0) ? 0 : m_tbl[ui] - 1;
            m_ghr = (m_ghr * 2 + int'(ut)) % (1 << HB);
            m_bc  = m_bc + 1;
            if (um) m_mc = m_mc + 1;
        end
    endtask

    task automatic check(input string tag, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, field, act, exp);
        end
    endtask

    // Monitor: outputs are settled by mid-cycle, well away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.tag, "predict_index", 32'(predict_index), e.idx);
                check(e.tag, "predict_taken", 32'(predict_taken), e.tk);
                check(e.tag, "branch_count", branch_count, e.bc);
                check(e.tag, "mispredict_count", mispredict_count, e.mc);
                $display("txn %-10s idx=0x%02h tk=%0d bc=%0d mc=0x%0h", e.tag,
                         predict_index, predict_taken, branch_count, mispredict_count);
            end
        end
    end

    initial begin
        int bits[4] = '{1, 0, 1, 1};

        // Reset wins over an update presented in the same cycle.
        cycle("rst", 1'b0, 32'h0, 1'b1, 3, 1'b1, 1'b1);
        cycle("rst2", 1'b0, 32'h1234_5678, 1'b1, 9, 1'b1, 1'b1);
        cycle("first", 1'b1, 32'h0000_0040, 1'b0, 0, 1'b0, 1'b0);

        repeat (5) cycle("nt_zero", 1'b1, pc_for(16), 1'b1, 16, 1'b0, 1'b0);
        cycle("nt_ghr", 1'b1, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        cycle("nt_entry", 1'b1, pc_for(16), 1'b0, 0, 1'b0, 1'b0);

        repeat (3) cycle("tk5", 1'b1, pc_for(5), 1'b1, 5, 1'b1, 1'b0);
        cycle("tk5_chk", 1'b1, pc_for(5), 1'b0, 0, 1'b0, 1'b0);
        cycle("tk5_sat", 1'b1, pc_for(5), 1'b1, 5, 1'b1, 1'b0);
        cycle("dec5", 1'b1, pc_for(5), 1'b1, 5, 1'b0, 1'b0);
        cycle("dec5_chk", 1'b1, pc_for(5), 1'b0, 0, 1'b0, 1'b0);

        cycle("rst", 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        cycle("tk7", 1'b1, pc_for(7), 1'b1, 7, 1'b1, 1'b0);
        cycle("same7", 1'b1, pc_for(7), 1'b1, 7, 1'b1, 1'b0);
        cycle("after7", 1'b1, pc_for(7), 1'b0, 0, 1'b0, 1'b0);

        cycle("rst", 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        foreach (bits[i]) cycle("hist", 1'b1, $urandom, 1'b1, 32, bits[i] != 0, 1'b0);
        cycle("hist_chk", 1'b1, 32'h0, 1'b0, 0, 1'b0, 1'b0);

        // Preload the miss counter just below wrap; inputs are idle across this edge.
        cycle("pre_wrap", 1'b1, $urandom, 1'b0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        force dut.mispredict_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.mispredict_count_reg;
        m_mc = 32'hFFFF_FFFF;
        cycle("wrap", 1'b1, $urandom, 1'b1, 3, 1'b0, 1'b1);
        cycle("wrap_chk", 1'b1, $urandom, 1'b1, 4, 1'b1, 1'b1);

        repeat (60) cycle("train", 1'b1, $urandom, 1'b1, int'($urandom_range(0, 7)),
                          1'b1, $urandom_range(0, 1) != 0);
        cycle("rst_mid", 1'b0, pc_for(2), 1'b1, 2, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle("post_rst", 1'b1, pc_for(i), 1'b0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            cycle("rand", $urandom_range(0, 59) != 0, $urandom, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, N - 1)), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) != 0);
        end
        cycle("idle", 1'b1, $urandom, 1'b0, 0, 1'b0, 1'b0);

        for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
